// File: rtl/elastic_pipeline_pkg.sv
// Shared types and helpers for the elastic pipeline.
// Popcount and saturating add used by the top level.
package elastic_pipeline_pkg;

  localparam int MAX_DEPTH = 16;
  localparam int PC_W = $clog2(MAX_DEPTH + 1);

  function automatic logic [PC_W-1:0] popcount(
    input logic [MAX_DEPTH-1:0] v
  );
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] max
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// Valid/ready bundle for both ends of the pipeline.
// The pipeline is the slave; its environment is the master.
interface elastic_pipeline_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/elastic_pipeline_stage.sv
// One pipeline register: valid bit plus payload.
// Flush beats load; payload only moves when valid data arrives.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_src_v,
  input  logic [WIDTH-1:0] i_src_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_d
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (i_load) begin
      r_v <= i_src_v;
      if (i_src_v)
        r_d <= i_src_d;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/elastic_pipeline.sv
// N-stage elastic pipeline with per-stage stall and flush.
// Ready chain runs back from out_ready and ignores flush.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  elastic_pipeline_if.slave          bus,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           kill_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [31:0] CNT_MAX =
    (CNT_W >= 32) ? 32'hFFFF_FFFF
                  : ((32'd1 << CNT_W) - 32'd1);

  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_d;
  logic [DEPTH:0]              w_rdy;
  logic [DEPTH-1:0]            w_src;
  logic [DEPTH-1:0]            w_up_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_up_d;
  logic [CNT_W-1:0]            r_kill;
  logic [PC_W-1:0]             w_nkill;

  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      w_rdy[i] = !stall[i] &&
                 (!w_v[i] || w_rdy[i+1]);
  end

  assign w_src = w_v & ~stall & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_up_v[g] = bus.in_valid;
      assign w_up_d[g] = bus.in_data;
    end else begin : g_body
      assign w_up_v[g] = w_src[g-1];
      assign w_up_d[g] = w_d[g-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (reset),
      .i_load  (w_rdy[g]),
      .i_flush (flush[g]),
      .i_src_v (w_up_v[g]),
      .i_src_d (w_up_d[g]),
      .o_v     (w_v[g]),
      .o_d     (w_d[g])
    );
  end

  assign w_nkill = popcount(MAX_DEPTH'(flush & w_v));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_kill <= '0;
    else
      r_kill <= CNT_W'(sat_add(32'(r_kill),
                               32'(w_nkill),
                               CNT_MAX));
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = w_src[DEPTH-1];
  assign bus.out_data  = w_d[DEPTH-1];
  assign stage_valid   = w_v;
  assign stage_data    = w_d;
  assign occupancy     = OCC_W'(popcount(MAX_DEPTH'(w_v)));
  assign kill_cnt      = r_kill;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed bench for elastic_pipeline: table-driven streaming
// plus hand sequences for backpressure, stall, flush and reset.
module tb_elastic_pipeline;

  localparam int W = 32;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [D-1:0] stall;
  logic [D-1:0] flush;

  logic [D-1:0]   sv;
  logic [D*W-1:0] sd;
  logic [2:0]     occ;
  logic [15:0]    kill;

  logic [D-1:0]   sv2;
  logic [D*W-1:0] sd2;
  logic [2:0]     occ2;
  logic [1:0]     kill2;

  int n_chk  = 0;
  int n_pass = 0;

  elastic_pipeline_if #(.WIDTH(W)) bus ();
  elastic_pipeline_if #(.WIDTH(W)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  elastic_pipeline #(
    .WIDTH (W), .DEPTH (D), .CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (sv),
    .stage_data  (sd),
    .occupancy   (occ),
    .kill_cnt    (kill)
  );

  elastic_pipeline #(
    .WIDTH (W), .DEPTH (D), .CNT_W (2)
  ) dut_sat (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus2),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (sv2),
    .stage_data  (sd2),
    .occupancy   (occ2),
    .kill_cnt    (kill2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         eov;
    logic [W-1:0] eod;
    logic         eir;
    logic [2:0]   eocc;
  } vec_t;

  vec_t tab[14];

  function automatic vec_t mk(
    input logic iv, input logic [W-1:0] id,
    input logic eov, input logic [W-1:0] eod,
    input logic [2:0] eocc
  );
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = 1'b1;
    v.eov = eov; v.eod = eod;
    v.eir = 1'b1; v.eocc = eocc;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    stall = '0;
    flush = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    idle();
    bus.out_ready = 1'b1;
  endtask

  task automatic fill5(input logic [W-1:0] base);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = base + W'(k);
      cyc();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    stall = 5'b00001;
    #1 chk("rst_in_ready_st0", 64'(bus.in_ready), 0);
    stall = '0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_stage_valid", 64'(sv), 0);
    chk("rst_occ", 64'(occ), 0);
    chk("rst_kill", 64'(kill), 0);
    rst_n = 1'b1;
    cyc();

    // streaming 0x1..0x8
    tab[0]  = mk(1, 32'h1, 0, 32'h0, 0);
    tab[1]  = mk(1, 32'h2, 0, 32'h0, 1);
    tab[2]  = mk(1, 32'h3, 0, 32'h0, 2);
    tab[3]  = mk(1, 32'h4, 0, 32'h0, 3);
    tab[4]  = mk(1, 32'h5, 0, 32'h0, 4);
    tab[5]  = mk(1, 32'h6, 1, 32'h1, 5);
    tab[6]  = mk(1, 32'h7, 1, 32'h2, 5);
    tab[7]  = mk(1, 32'h8, 1, 32'h3, 5);
    tab[8]  = mk(0, 32'h0, 1, 32'h4, 5);
    tab[9]  = mk(0, 32'h0, 1, 32'h5, 4);
    tab[10] = mk(0, 32'h0, 1, 32'h6, 3);
    tab[11] = mk(0, 32'h0, 1, 32'h7, 2);
    tab[12] = mk(0, 32'h0, 1, 32'h8, 1);
    tab[13] = mk(0, 32'h0, 0, 32'h8, 0);
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = tab[i].iv;
      bus.in_data = tab[i].id;
      bus.out_ready = tab[i].ordy;
      #1;
      chk($sformatf("str%0d_ov", i),
          64'(bus.out_valid), 64'(tab[i].eov));
      chk($sformatf("str%0d_od", i),
          64'(bus.out_data), 64'(tab[i].eod));
      chk($sformatf("str%0d_ir", i),
          64'(bus.in_ready), 64'(tab[i].eir));
      chk($sformatf("str%0d_occ", i),
          64'(occ), 64'(tab[i].eocc));
      cyc();
    end

    // backpressure with bubble collapse
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h21;
    #1 chk("bp_ir0", 64'(bus.in_ready), 1);
    cyc();
    bus.in_data = 32'h22;
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    chk("bp_sv", 64'(sv), 64'(5'b11000));
    chk("bp_s4", 64'(sd[4*W +: W]), 64'h21);
    chk("bp_s3", 64'(sd[3*W +: W]), 64'h22);
    chk("bp_ov", 64'(bus.out_valid), 1);
    cyc();
    chk("bp_hold_sv", 64'(sv), 64'(5'b11000));
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'h23 + W'(k);
      #1 chk($sformatf("bp_fill%0d_ir", k),
             64'(bus.in_ready), 1);
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("bp_full_ir", 64'(bus.in_ready), 0);
    chk("bp_full_occ", 64'(occ), 5);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_out%0d_ov", k),
          64'(bus.out_valid), 1);
      chk($sformatf("bp_out%0d_od", k),
          64'(bus.out_data), 64'(32'h21 + k));
      cyc();
    end
    chk("bp_drained", 64'(bus.out_valid), 0);

    // load-use stall on stage 1
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data = 32'hA;
    cyc();
    bus.in_data = 32'hB;
    cyc();
    bus.in_data = 32'hC;
    stall = 5'b00010;
    #1 chk("lu_ir_stall", 64'(bus.in_ready), 0);
    cyc();
    stall = '0;
    #1;
    chk("lu_bubble_sv", 64'(sv), 64'(5'b00011));
    chk("lu_ir_resume", 64'(bus.in_ready), 1);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    begin
      logic [4:0]   ev;
      logic [W-1:0] ed[5];
      ev = 5'b01110;
      ed[0] = 32'h0; ed[1] = 32'hA;
      ed[2] = 32'hB; ed[3] = 32'hC;
      ed[4] = 32'hC;
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("lu%0d_ov", k),
            64'(bus.out_valid), 64'(ev[k]));
        if (ev[k])
          chk($sformatf("lu%0d_od", k),
              64'(bus.out_data), 64'(ed[k]));
        cyc();
      end
    end

    // branch flush of stages 0 and 1
    do_reset();
    fill5(32'h10);
    flush = 5'b00011;
    #1;
    chk("br_occ_pre", 64'(occ), 5);
    chk("br_kill_pre", 64'(kill), 0);
    cyc();
    flush = '0;
    #1;
    chk("br_kill", 64'(kill), 2);
    chk("br_kill_sat", 64'(kill2), 2);
    chk("br_occ", 64'(occ), 3);
    chk("br_sv", 64'(sv), 64'(5'b11100));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("br_out%0d_ov", k),
          64'(bus.out_valid), 1);
      chk($sformatf("br_out%0d_od", k),
          64'(bus.out_data), 64'(32'h10 + k));
      cyc();
    end
    chk("br_done_ov", 64'(bus.out_valid), 0);

    // flush + stall + input on stage 0
    bus.in_valid = 1'b1;
    bus.in_data = 32'h30;
    cyc();
    stall = 5'b00001;
    flush = 5'b00001;
    bus.in_data = 32'h31;
    #1 chk("fs_ir", 64'(bus.in_ready), 0);
    cyc();
    idle();
    #1;
    chk("fs_sv", 64'(sv), 0);
    chk("fs_kill", 64'(kill), 3);
    stall = 5'b00001;
    flush = 5'b00001;
    bus.in_valid = 1'b1;
    cyc();
    idle();
    #1;
    chk("fs_empty_kill", 64'(kill), 3);
    flush = 5'b00001;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h40;
    #1 chk("fl_in_ir", 64'(bus.in_ready), 1);
    cyc();
    idle();
    #1;
    chk("fl_in_sv", 64'(sv), 0);
    chk("fl_in_kill", 64'(kill), 3);
    repeat (5) cyc();
    chk("fl_in_none_out", 64'(bus.out_valid), 0);

    // saturation with CNT_W=2
    do_reset();
    fill5(32'h50);
    flush = 5'b11111;
    cyc();
    flush = '0;
    #1;
    chk("sat_kill16", 64'(kill), 5);
    chk("sat_kill2", 64'(kill2), 3);
    chk("sat_sv", 64'(sv), 0);

    // async reset mid-cycle
    fill5(32'h60);
    #1 chk("ar_pre_ov", 64'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 64'(bus.out_valid), 0);
    chk("ar_od", 64'(bus.out_data), 0);
    chk("ar_sv", 64'(sv), 0);
    chk("ar_sd", 64'(sd[63:0]), 0);
    chk("ar_occ", 64'(occ), 0);
    chk("ar_kill", 64'(kill), 0);
    chk("ar_kill2", 64'(kill2), 0);
    chk("ar_ir", 64'(bus.in_ready), 1);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/elastic_pipeline.md
Name: elastic_pipeline

Overview:
- Parametrised N-stage pipeline datapath with a per-stage valid bit, valid/ready handshakes at both ends, per-stage stall and per-stage flush.
- Supersedes the fixed always-enabled per-field register chains between CPU stages; stages can now be held (load-use hazards) and squashed (taken branch/jump).
- Empty stages absorb upstream data even when downstream is blocked (bubble collapse).
- Keeps a saturating count of squashed valid entries for debug.

Parameters:
WIDTH, 32, payload bits carried per stage (packed instruction fields plus control)
DEPTH, 5, number of stages; legal range 2..16
CNT_W, 16, width of kill counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
in_valid  in  1  upstream presents in_data
in_data  in  WIDTH  payload entering stage 0
in_ready  out  1  stage 0 can accept this cycle
stall  in  DEPTH  bit i: stage i holds its contents and accepts nothing
flush  in  DEPTH  bit i: stage i contents killed at next edge
out_valid  out  1  stage DEPTH-1 presents out_data
out_data  out  WIDTH  payload of stage DEPTH-1
out_ready  in  1  downstream consumes out_data
stage_valid  out  DEPTH  registered valid bit of each stage
stage_data  out  DEPTH*WIDTH  registered payloads, stage 0 in LSBs
occupancy  out  $clog2(DEPTH+1)  number of set stage_valid bits
kill_cnt  out  CNT_W  valid entries removed by flush, saturating

Behaviour:
- State per stage i: v[i], d[i].
- Reset (reset low, async): every v, d, and kill_cnt = 0. Outputs are then out_valid=0, out_data=0, stage_valid=0, occupancy=0, in_ready=!stall[0].
- Ready chain (combinational, flush-independent to avoid loops):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !stall[i] && (!v[i] || rdy[i+1]).
  - in_ready = rdy[0].
- Source valid:
  - src[i] = v[i] && !stall[i] && !flush[i].
  - src[-1] = in_valid.
- out_valid = src[DEPTH-1]. out_data = d[DEPTH-1].
- Per-edge update for stage i, in priority order:
  - flush[i]: v[i] <= 0. d is don't-care but hold it. This also discards any entry that would enter stage i.
  - else if rdy[i]: v[i] <= src[i-1]; d[i] <= source data when src[i-1], else hold.
  - else: hold.
- A stage whose v[i]=1 and rdy[i]=1 at an edge transfers its payload onward; the payload is never duplicated.
- An input handshake (in_valid && in_ready) during flush[0] is consumed and discarded.
- stall[i] with rdy[i+1]=1: stage i holds; stage i+1 receives a bubble.
- flush and stall on the same stage: flush wins; the stage empties.
- Latency: with no stall/flush and out_ready=1, an entry accepted at edge k is out_valid in the cycle after edge k+DEPTH-1. Throughput is 1 per cycle.
- kill_cnt increments by popcount(flush & v) per edge and saturates at 2^CNT_W-1 with no wrap. Stalled or bubble stages that are flushed count only if v=1.
- occupancy reflects registered v only.

Decomposition:
- Package elastic_pipeline_pkg holds:
  - MAX_DEPTH=16.
  - popcount function for DEPTH-bit vectors.
  - saturating-add function.
- Sub-module pipe_stage holds one stage: valid plus WIDTH-bit payload, with load/flush inputs and async active-low reset.
- Top level generates DEPTH instances and the ready chain.

Test Plan:
- Streaming: reset, DEPTH=5, stream 0x1..0x8 back-to-back, stall=0, out_ready=1 -> 0x1 out_valid 5 cycles after acceptance; one word per cycle in order; occupancy reaches 5.
- Backpressure collapse: fill stages 0 and 1 only, out_ready=0 for 6 cycles -> both entries advance to stages 4 and 3; in_ready stays 1 until all 5 valid; no data lost when out_ready returns.
- Load-use stall: stall[1]=1 for 1 cycle with stream 0xA,0xB,0xC -> stage 2 holds a bubble for one cycle; in_ready=0 that cycle; output order 0xA,0xB,0xC with a one-cycle gap.
- Branch flush: full pipe 0x10..0x14, flush=5'b00011 for one edge -> 0x14 and 0x13 (stages 0,1) removed; kill_cnt=2; 0x10..0x12 emerge; occupancy drops by 2.
- Flush+stall+input together: stall[0]=1, flush[0]=1, in_valid=1 -> stage 0 empty next cycle; in_ready=0 so no input consumed; kill_cnt +1 only if stage 0 was valid.
- Async reset mid-stream plus saturation: drop reset low mid-cycle -> all outputs 0 immediately, no clock needed. With CNT_W=2, flush 5 valid entries -> kill_cnt=3.
